// File: rtl/mitchel.sv
// mitchel: 9-bit sign-magnitude approximate multiplier based on Mitchell's
// logarithm algorithm. It has a registered 17-bit sign-magnitude product and
// a latency of one cycle.
module mitchel (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    output logic [16:0] p
);

    localparam int unsigned MAG_W  = 8;
    localparam int unsigned FRAC_W = 7;
    localparam int unsigned CHAR_W = 4;
    localparam int unsigned LOG_W  = 11;
    localparam int unsigned ANTI_W = 23;
    localparam int unsigned PMAG_W = 16;
    localparam int unsigned P_W    = 17;

    logic [MAG_W-1:0]  a_mag;
    logic [MAG_W-1:0]  b_mag;
    logic [2:0]        ka;
    logic [2:0]        kb;
    logic [FRAC_W-1:0] fa;
    logic [FRAC_W-1:0] fb;
    logic [CHAR_W-1:0] char_sum;
    logic [LOG_W-1:0]  log_sum;
    logic [PMAG_W-1:0] mag;
    logic [P_W-1:0]    p_d;
    logic [P_W-1:0]    p_q;

    // Index of the most significant set bit; 0 when v is 0 (v == 0 is masked later)
    function automatic logic [2:0] lead_one(input logic [MAG_W-1:0] v);
        logic [2:0] k;
        k = '0;
        for (int i = 0; i < int'(MAG_W); i++) begin
            if (v[i]) begin
                k = 3'(i);
            end
        end
        return k;
    endfunction

    // Log-domain add followed by a truncating antilog, with zero and sign handling
    always_comb begin
        a_mag    = x[MAG_W-1:0];
        b_mag    = y[MAG_W-1:0];
        ka       = lead_one(a_mag);
        kb       = lead_one(b_mag);
        // Normalise so the leading one sits at bit 7, then drop it to leave the mantissa
        fa       = FRAC_W'(a_mag << (3'd7 - ka));
        fb       = FRAC_W'(b_mag << (3'd7 - kb));
        char_sum = CHAR_W'(ka) + CHAR_W'(kb);
        // A carry out of the mantissa add moves into the characteristic
        log_sum  = {char_sum, 7'b0} + LOG_W'(fa) + LOG_W'(fb);
        // The antilog is evaluated in 23 bits; the low bits are truncated, never rounded
        mag      = PMAG_W'((ANTI_W'({1'b1, log_sum[FRAC_W-1:0]})
                            << log_sum[LOG_W-1:FRAC_W]) >> FRAC_W);
        p_d      = '0;
        if ((a_mag != '0) && (b_mag != '0)) begin
            p_d = {x[8] ^ y[8], mag};
        end
    end

    // Output register; reset overrides the in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_mitchel.sv
// tb_mitchel: directed, random and exhaustive checks of the mitchel multiplier
// against a closed-form floor model.
module tb_mitchel;

    logic        clk;
    logic        rst;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [16:0] p;

    int checks;
    int failures;

    mitchel dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .p   (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h (%0d) exp=%h (%0d)", tag, got, got[15:0], exp, exp[15:0]);
        end
    endtask

    // Closed-form Mitchell model: floor(2^(ka+kb)(1+xa+xb)) or floor(2^(ka+kb+1)(xa+xb))
    function automatic logic [16:0] model(input logic [8:0] xa, input logic [8:0] yb);
        int    a;
        int    b;
        int    ka;
        int    kb;
        int    fa;
        int    fb;
        int    s;
        longint m;
        a = int'(xa[7:0]);
        b = int'(yb[7:0]);
        if (a == 0 || b == 0) return 17'h0;
        ka = 0;
        while ((a >> (ka + 1)) != 0) ka++;
        kb = 0;
        while ((b >> (kb + 1)) != 0) kb++;
        fa = ((a - (1 << ka)) * 128) >> ka;
        fb = ((b - (1 << kb)) * 128) >> kb;
        s  = fa + fb;
        if (s < 128) m = (longint'(128 + s) << (ka + kb)) >> 7;
        else         m = (longint'(s) << (ka + kb + 1)) >> 7;
        return {xa[8] ^ yb[8], 16'(m)};
    endfunction

    // Drive one operand pair (and reset) for a cycle, then settle after the edge
    task automatic step(input logic [8:0] xv, input logic [8:0] yv, input logic rv);
        @(negedge clk);
        x   = xv;
        y   = yv;
        rst = rv;
        @(posedge clk);
        #1;
    endtask

    localparam int unsigned N_DIR = 16;
    logic [8:0]  dir_x [N_DIR];
    logic [8:0]  dir_y [N_DIR];
    logic [16:0] dir_p [N_DIR];

    initial begin
        logic [8:0]  rx;
        logic [8:0]  ry;
        longint      tp;
        longint      mg;
        logic        ok;

        checks   = 0;
        failures = 0;

        // Hand-derived Mitchell results
        dir_x[0]  = 9'd5;    dir_y[0]  = 9'd3;    dir_p[0]  = 17'd14;
        dir_x[1]  = 9'd15;   dir_y[1]  = 9'd5;    dir_p[1]  = 17'd72;
        dir_x[2]  = 9'd50;   dir_y[2]  = 9'd7;    dir_p[2]  = 17'd336;
        dir_x[3]  = 9'd25;   dir_y[3]  = 9'd6;    dir_p[3]  = 17'd136;
        dir_x[4]  = 9'd253;  dir_y[4]  = 9'd253;  dir_p[4]  = 17'h0FA00;
        dir_x[5]  = 9'd20;   dir_y[5]  = 9'd4;    dir_p[5]  = 17'd80;
        dir_x[6]  = 9'd8;    dir_y[6]  = 9'd2;    dir_p[6]  = 17'd16;
        dir_x[7]  = 9'd129;  dir_y[7]  = 9'd65;   dir_p[7]  = 17'd8384;
        dir_x[8]  = 9'd1;    dir_y[8]  = 9'd1;    dir_p[8]  = 17'd1;
        dir_x[9]  = 9'd255;  dir_y[9]  = 9'd1;    dir_p[9]  = 17'd255;
        dir_x[10] = 9'h105;  dir_y[10] = 9'd3;    dir_p[10] = 17'h1000E;
        dir_x[11] = 9'h114;  dir_y[11] = 9'h104;  dir_p[11] = 17'd80;
        dir_x[12] = 9'h1FD;  dir_y[12] = 9'h1FD;  dir_p[12] = 17'd64000;
        dir_x[13] = 9'd0;    dir_y[13] = 9'd18;   dir_p[13] = 17'd0;
        dir_x[14] = 9'h100;  dir_y[14] = 9'h105;  dir_p[14] = 17'd0;
        dir_x[15] = 9'd3;    dir_y[15] = 9'h103;  dir_p[15] = 17'h10008;

        rst = 1'b1;
        x   = 9'd255;
        y   = 9'd255;

        // Reset held with live operands: output stays zero
        for (int i = 0; i < 3; i++) begin
            step(9'd255, 9'd255, 1'b1);
            check_eq($sformatf("reset_hold%0d", i), p, 17'h0);
        end

        // Release: first valid result one cycle later
        step(9'd255, 9'd255, 1'b0);
        check_eq("reset_release", p, 17'd65024);

        // Directed vectors, one pair per cycle
        for (int i = 0; i < int'(N_DIR); i++) begin
            step(dir_x[i], dir_y[i], 1'b0);
            check_eq($sformatf("dir%0d", i), p, dir_p[i]);
        end

        // Mid-stream reset discards the in-flight result, then results resume
        step(9'd50, 9'd7, 1'b1);
        check_eq("mid_reset", p, 17'h0);
        step(9'h10F, 9'd5, 1'b0);
        check_eq("mid_resume", p, 17'h10048);

        // Back-to-back random pairs with an accuracy bound
        for (int i = 0; i < 256; i++) begin
            rx = 9'($urandom);
            ry = 9'($urandom);
            step(rx, ry, 1'b0);
            check_eq($sformatf("rand%0d", i), p, model(rx, ry));
            tp = longint'(rx[7:0]) * longint'(ry[7:0]);
            mg = longint'(p[15:0]);
            ok = (mg <= tp) && (mg * 1000 >= tp * 888);
            check_eq($sformatf("bound%0d", i), {16'b0, ok}, 17'd1);
        end

        // Every magnitude pair with random signs
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                rx = {1'($urandom), 8'(a)};
                ry = {1'($urandom), 8'(b)};
                step(rx, ry, 1'b0);
                check_eq($sformatf("exh_%0d_%0d", a, b), p, model(rx, ry));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
